bitmap_frame_scheduler: RTL and testbench

Frame-level controller that sequences the bitmap renderer. It accepts screen requests from game logic over a valid/ready handshake and holds one request pending. At each frame boundary it re-arms the renderer by pulsing the renderer's reset with the selected bitmap start address. It also enforces minimum display durations and generates a frame-locked blink phase.

---
 rtl/bitmap_frame_scheduler_pkg.sv | 16 +
 rtl/bitmap_frame_scheduler_tick_detect.sv | 34 +++
 rtl/bitmap_frame_scheduler.sv | 116 +++++++++++
 tb/tb_bitmap_frame_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bitmap_frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: state encodings and default
// display timing constants, kept alongside the bitmap ROM definitions.
package bitmap_frame_scheduler_pkg;

  typedef enum logic {
    SchedState_blank = 1'b0,
    SchedState_show  = 1'b1
  } schedState_t;

  localparam int PixelBits          = 10;
  localparam int FrameCountBits     = 8;
  localparam int DefaultHLast       = 799;
  localparam int DefaultVLast       = 524;
  localparam int DefaultBlinkFrames = 30;

endpackage

// File: rtl/bitmap_frame_scheduler_tick_detect.sv
// Produces one tick per frame, on the first cycle the scan position reaches
// the last pixel, even when the pixel counters dwell for several clocks.
module frame_tick_detect
  import bitmap_frame_scheduler_pkg::*;
#(
  parameter int HLast = DefaultHLast,
  parameter int VLast = DefaultVLast
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [PixelBits-1:0] currX,
  input  logic [PixelBits-1:0] currY,
  output logic                 tick
);

  localparam logic [PixelBits-1:0] XLast = PixelBits'(HLast);
  localparam logic [PixelBits-1:0] YLast = PixelBits'(VLast);

  logic match;
  logic matchPrev;

  assign match = (currX == XLast) && (currY == YLast);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      matchPrev <= 1'b0;
    end else begin
      matchPrev <= match;
    end
  end

  assign tick = match && !matchPrev;

endmodule

// File: rtl/bitmap_frame_scheduler.sv
// Frame-level renderer sequencer: holds one pending screen request and
// re-arms the bitmap renderer at every frame boundary.
module bitmap_frame_scheduler
  import bitmap_frame_scheduler_pkg::*;
#(
  parameter int AddrBits    = 10,
  parameter int HLast       = DefaultHLast,
  parameter int VLast       = DefaultVLast,
  parameter int BlinkFrames = DefaultBlinkFrames
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [PixelBits-1:0]      CURR_X_PIXEL,
  input  logic [PixelBits-1:0]      CURR_Y_PIXEL,
  input  logic                      REQ_VALID,
  input  logic [AddrBits-1:0]       REQ_ADDR,
  input  logic [FrameCountBits-1:0] REQ_FRAMES,
  output logic                      REQ_READY,
  input  logic                      CLEAR,
  output logic                      RENDER_RESET,
  output logic [AddrBits-1:0]       RENDER_ADDR,
  output logic                      BLINK_ON,
  output logic                      SCREEN_DONE
);

  localparam int BlinkBits = $clog2(BlinkFrames) + 1;
  localparam logic [BlinkBits-1:0] BlinkLast = BlinkBits'(BlinkFrames - 1);

  schedState_t               state;
  logic                      pendValid;
  logic [AddrBits-1:0]       pendAddr;
  logic [FrameCountBits-1:0] pendFrames;
  logic                      clearReq;
  logic [FrameCountBits-1:0] remain;
  logic [BlinkBits-1:0]      blinkCnt;
  logic                      tick;
  logic                      accept;
  logic                      loadNow;

  frame_tick_detect #(
    .HLast(HLast),
    .VLast(VLast)
  ) tickDetect (
    .CLK  (CLK),
    .RESET(RESET),
    .currX(CURR_X_PIXEL),
    .currY(CURR_Y_PIXEL),
    .tick (tick)
  );

  assign REQ_READY = !pendValid && !RESET;
  assign accept    = REQ_VALID && REQ_READY;
  // A pending screen may replace the current one only once its hold is over.
  assign loadNow   = pendValid &&
                     ((state == SchedState_blank) || (remain <= FrameCountBits'(1)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= SchedState_blank;
      pendValid    <= 1'b0;
      pendAddr     <= '0;
      pendFrames   <= '0;
      clearReq     <= 1'b0;
      remain       <= '0;
      blinkCnt     <= '0;
      RENDER_RESET <= 1'b1;
      RENDER_ADDR  <= '0;
      BLINK_ON     <= 1'b1;
      SCREEN_DONE  <= 1'b0;
    end else begin
      RENDER_RESET <= tick || (state == SchedState_blank);
      SCREEN_DONE  <= 1'b0;

      if (accept) begin
        pendValid  <= 1'b1;
        pendAddr   <= REQ_ADDR;
        pendFrames <= REQ_FRAMES;
      end

      if (tick) begin
        if (clearReq) begin
          state    <= SchedState_blank;
          remain   <= '0;
          clearReq <= 1'b0;
          blinkCnt <= '0;
          BLINK_ON <= 1'b1;
        end else if (loadNow) begin
          RENDER_ADDR <= pendAddr;
          remain      <= pendFrames;
          pendValid   <= 1'b0;
          state       <= SchedState_show;
          blinkCnt    <= '0;
          BLINK_ON    <= 1'b1;
          SCREEN_DONE <= (state == SchedState_show) && (remain == FrameCountBits'(1));
        end else if (state == SchedState_show) begin
          if (remain != '0) begin
            remain      <= remain - FrameCountBits'(1);
            SCREEN_DONE <= (remain == FrameCountBits'(1));
          end
          if (blinkCnt == BlinkLast) begin
            blinkCnt <= '0;
            BLINK_ON <= !BLINK_ON;
          end else begin
            blinkCnt <= blinkCnt + BlinkBits'(1);
          end
        end
      end

      // Set after the tick handling so a strobe in a tick cycle waits a frame.
      if (CLEAR) begin
        clearReq <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_frame_scheduler.sv
// Directed vector bench for bitmap_frame_scheduler using a shrunk frame
// (10x5 pixels) and a two-frame blink half-period.
module tb_bitmap_frame_scheduler;

  localparam int HL = 9;
  localparam int VL = 4;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [9:0] addr;
    logic [7:0] frames;
    logic       clr;
    logic       tk;
    logic       expRR;
    logic [9:0] expAddr;
    logic       expBlink;
    logic       expDone;
    logic       expReady;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [9:0] CURR_X_PIXEL;
  logic [9:0] CURR_Y_PIXEL;
  logic       REQ_VALID;
  logic [9:0] REQ_ADDR;
  logic [7:0] REQ_FRAMES;
  logic       REQ_READY;
  logic       CLEAR;
  logic       RENDER_RESET;
  logic [9:0] RENDER_ADDR;
  logic       BLINK_ON;
  logic       SCREEN_DONE;

  int vecCount  = 0;
  int missCount = 0;

  vec_t vecs[44];

  bitmap_frame_scheduler #(
    .AddrBits   (10),
    .HLast      (HL),
    .VLast      (VL),
    .BlinkFrames(2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CURR_X_PIXEL(CURR_X_PIXEL),
    .CURR_Y_PIXEL(CURR_Y_PIXEL),
    .REQ_VALID   (REQ_VALID),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_FRAMES  (REQ_FRAMES),
    .REQ_READY   (REQ_READY),
    .CLEAR       (CLEAR),
    .RENDER_RESET(RENDER_RESET),
    .RENDER_ADDR (RENDER_ADDR),
    .BLINK_ON    (BLINK_ON),
    .SCREEN_DONE (SCREEN_DONE)
  );

  always #5 CLK = !CLK;

  function automatic vec_t mk(input logic rst, input logic valid, input logic [9:0] addr,
                              input logic [7:0] frames, input logic clr, input logic tk,
                              input logic rr, input logic [9:0] ea, input logic bl,
                              input logic dn, input logic rd);
    vec_t v;
    v.rst = rst; v.valid = valid; v.addr = addr; v.frames = frames; v.clr = clr; v.tk = tk;
    v.expRR = rr; v.expAddr = ea; v.expBlink = bl; v.expDone = dn; v.expReady = rd;
    return v;
  endfunction

  // Drive one clock of inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    RESET        = v.rst;
    REQ_VALID    = v.valid;
    REQ_ADDR     = v.addr;
    REQ_FRAMES   = v.frames;
    CLEAR        = v.clr;
    CURR_X_PIXEL = v.tk ? 10'(HL) : 10'd0;
    CURR_Y_PIXEL = v.tk ? 10'(VL) : 10'd0;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    vecCount++;
    if (RENDER_RESET !== v.expRR || RENDER_ADDR !== v.expAddr || BLINK_ON !== v.expBlink ||
        SCREEN_DONE !== v.expDone || REQ_READY !== v.expReady) begin
      missCount++;
      $display("[TB] FAIL vec%0d rr/addr/blink/done/ready actual=%b/%h/%b/%b/%b required=%b/%h/%b/%b/%b",
               idx, RENDER_RESET, RENDER_ADDR, BLINK_ON, SCREEN_DONE, REQ_READY,
               v.expRR, v.expAddr, v.expBlink, v.expDone, v.expReady);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int required);
    vecCount++;
    if (actual != required) begin
      missCount++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  initial begin
    int rrCount;
    logic expBlinkSeq[4];
    vec_t idle;

    RESET = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_FRAMES = '0; CLEAR = 1'b0;
    CURR_X_PIXEL = '0; CURR_Y_PIXEL = '0;

    //            rst vld addr    frm clr tk | rr addr    bl dn rdy
    vecs[0]  = mk(1, 0, 10'h000, 0, 0, 0,    1, 10'h000, 1, 0, 0);
    vecs[1]  = mk(0, 0, 10'h000, 0, 0, 0,    1, 10'h000, 1, 0, 1);
    vecs[2]  = mk(0, 1, 10'h040, 0, 0, 0,    1, 10'h000, 1, 0, 0);
    vecs[3]  = mk(0, 0, 10'h000, 0, 0, 0,    1, 10'h000, 1, 0, 0);
    vecs[4]  = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h040, 1, 0, 1);
    vecs[5]  = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h040, 1, 0, 1);
    vecs[6]  = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h040, 1, 0, 1);
    vecs[7]  = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h040, 1, 0, 1);
    vecs[8]  = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h040, 0, 0, 1);
    vecs[9]  = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h040, 0, 0, 1);
    // Screen A held three frames, B queued behind it.
    vecs[10] = mk(0, 1, 10'h100, 3, 0, 0,    0, 10'h040, 0, 0, 0);
    vecs[11] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h100, 1, 0, 1);
    vecs[12] = mk(0, 1, 10'h200, 2, 0, 0,    0, 10'h100, 1, 0, 0);
    vecs[13] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h100, 1, 0, 0);
    vecs[14] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h100, 1, 0, 0);
    vecs[15] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h100, 0, 0, 0);
    vecs[16] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h100, 0, 0, 0);
    vecs[17] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h200, 1, 1, 1);
    vecs[18] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h200, 1, 0, 1);
    vecs[19] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h200, 1, 0, 1);
    vecs[20] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h200, 1, 0, 1);
    vecs[21] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h200, 0, 1, 1);
    vecs[22] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h200, 0, 0, 1);
    vecs[23] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h200, 0, 0, 1);
    // CLEAR and a pending request meet at the same tick.
    vecs[24] = mk(0, 1, 10'h0AA, 5, 0, 0,    0, 10'h200, 0, 0, 0);
    vecs[25] = mk(0, 0, 10'h000, 0, 1, 0,    0, 10'h200, 0, 0, 0);
    vecs[26] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h200, 1, 0, 0);
    vecs[27] = mk(0, 1, 10'h222, 1, 0, 0,    1, 10'h200, 1, 0, 0);
    vecs[28] = mk(0, 1, 10'h222, 1, 0, 1,    1, 10'h0AA, 1, 0, 1);
    vecs[29] = mk(0, 1, 10'h222, 1, 0, 0,    0, 10'h0AA, 1, 0, 0);
    vecs[30] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h0AA, 1, 0, 0);
    vecs[31] = mk(0, 0, 10'h000, 0, 1, 0,    0, 10'h0AA, 1, 0, 0);
    vecs[32] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h0AA, 1, 0, 0);
    vecs[33] = mk(0, 0, 10'h000, 0, 0, 0,    1, 10'h0AA, 1, 0, 0);
    vecs[34] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h222, 1, 0, 1);
    // Reset lands on a tick that would otherwise end a one-frame screen.
    vecs[35] = mk(0, 1, 10'h333, 0, 0, 0,    0, 10'h222, 1, 0, 0);
    vecs[36] = mk(1, 0, 10'h000, 0, 0, 1,    1, 10'h000, 1, 0, 0);
    vecs[37] = mk(0, 0, 10'h000, 0, 0, 0,    1, 10'h000, 1, 0, 1);
    vecs[38] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h000, 1, 0, 1);
    vecs[39] = mk(0, 0, 10'h000, 0, 0, 0,    1, 10'h000, 1, 0, 1);
    // Last pixel held two cycles must give a single tick.
    vecs[40] = mk(0, 1, 10'h3FF, 0, 0, 0,    1, 10'h000, 1, 0, 0);
    vecs[41] = mk(0, 0, 10'h000, 0, 0, 1,    1, 10'h3FF, 1, 0, 1);
    vecs[42] = mk(0, 0, 10'h000, 0, 0, 1,    0, 10'h3FF, 1, 0, 1);
    vecs[43] = mk(0, 0, 10'h000, 0, 0, 0,    0, 10'h3FF, 1, 0, 1);

    for (int i = 0; i < 44; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Slow scan: pixel counters advance every second clock over four frames.
    idle = mk(0, 1, 10'h155, 0, 0, 0, 0, 10'h3FF, 1, 0, 0);
    applyStimulus(idle);
    checkOutput(44, idle);
    REQ_VALID = 1'b0;
    expBlinkSeq[0] = 1'b1; expBlinkSeq[1] = 1'b1; expBlinkSeq[2] = 1'b0; expBlinkSeq[3] = 1'b0;
    for (int f = 0; f < 4; f++) begin
      rrCount = 0;
      for (int y = 0; y <= VL; y++) begin
        for (int x = 0; x <= HL; x++) begin
          for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            CURR_X_PIXEL = 10'(x);
            CURR_Y_PIXEL = 10'(y);
            @(posedge CLK);
            #1;
            if (RENDER_RESET) rrCount++;
          end
        end
      end
      checkValue($sformatf("frame%0d rrCount", f), rrCount, 1);
      checkValue($sformatf("frame%0d blinkOn", f), int'(BLINK_ON), int'(expBlinkSeq[f]));
    end
    checkValue("slowScan renderAddr", int'(RENDER_ADDR), 'h155);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
